// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension execution unit: funct3 op codes,
// FSM state encoding and op-class helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV_PREP,
        ST_DIV_ITER,
        ST_DIV_FIX,
        ST_DONE
    } state_t;

    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic is_signed_div(input logic [2:0] f);
        return (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned restoring shift-subtract divider, one quotient bit per cycle.
// The start edge already performs the first iteration.
module muldiv_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]   cnt_q;
    logic            run_q;

    logic [XLEN-1:0] src_rem, src_quo, src_dvs, nxt_rem, nxt_quo;
    logic [XLEN:0]   trial;

    always_comb begin
        src_rem = start ? '0       : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dvs = start ? divisor  : dvs_q;
        trial   = {src_rem, src_quo[XLEN-1]} - {1'b0, src_dvs};
        // A borrow means the trial subtraction is discarded (restore)
        nxt_rem = trial[XLEN] ? {src_rem[XLEN-2:0], src_quo[XLEN-1]} : trial[XLEN-1:0];
        nxt_quo = {src_quo[XLEN-2:0], ~trial[XLEN]};
    end

    // Strobes on the cycle whose edge completes the final iteration
    assign done      = run_q && (cnt_q == CW'(XLEN - 1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (clr) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            dvs_q <= divisor;
            cnt_q <= CW'(1);
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            cnt_q <= cnt_q + 1'b1;
            if (done)
                run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32IM EX-stage M-extension unit: registered multiply, iterative divide,
// valid/ready handshake and synchronous flush.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t state_q, state_d;

    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, res_q;
    logic            negq_q, negr_q;

    logic accept, div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    assign accept   = (state_q == ST_IDLE) && in_valid && !flush;
    assign div_zero = (op_b == '0);
    assign div_ovf  = is_signed_div(funct3) && (op_a == MOST_NEG) && (op_b == '1);
    assign special  = is_div(funct3) && (div_zero || div_ovf);

    always_comb begin
        if (funct3[1])
            special_res = div_zero ? op_a : '0;
        else
            special_res = div_zero ? '1 : op_a;
    end

    logic              a_sgn, b_sgn;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0]   mul_res;

    assign a_sgn   = (op_q != F3_MULHU);
    assign b_sgn   = (op_q == F3_MULH);
    assign mul_a   = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
    assign mul_b   = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
    assign prod    = mul_a * mul_b;
    assign mul_res = (op_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    logic            div_sgn, div_done;
    logic [XLEN-1:0] mag_a, mag_b, quo, rem, fix_res;

    assign div_sgn = is_signed_div(op_q);
    assign mag_a   = (div_sgn && a_q[XLEN-1]) ? -a_q : a_q;
    assign mag_b   = (div_sgn && b_q[XLEN-1]) ? -b_q : b_q;
    assign fix_res = op_q[1] ? (negr_q ? -rem : rem) : (negq_q ? -quo : quo);

    muldiv_div_core #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .start     (state_q == ST_DIV_PREP),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_div(funct3)) state_d = ST_MUL;
                    else if (special)    state_d = ST_DONE;
                    else                 state_d = ST_DIV_PREP;
                end
            end
            ST_MUL:      state_d = ST_DONE;
            ST_DIV_PREP: state_d = ST_DIV_ITER;
            ST_DIV_ITER: if (div_done) state_d = ST_DIV_FIX;
            ST_DIV_FIX:  state_d = ST_DONE;
            ST_DONE:     if (out_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (flush)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else if (!flush) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q <= funct3;
                        a_q  <= op_a;
                        b_q  <= op_b;
                        if (special)
                            res_q <= special_res;
                    end
                end
                ST_MUL: res_q <= mul_res;
                ST_DIV_PREP: begin
                    negq_q <= div_sgn && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                    negr_q <= div_sgn && a_q[XLEN-1];
                end
                ST_DIV_FIX: res_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = res_q;

endmodule
